// File: rtl/keypad_hex_entry_pkg.sv
// Shared definitions for the keypad hex entry path: FSM states, column reset pattern
// and the {row,col} -> hex legend table.
package keypad_hex_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Index is {row,col}; relabel entries here if the keypad legend differs from identity.
  localparam logic [3:0] KEY_HEX [16] = '{
    4'h0, 4'h1, 4'h2, 4'h3,
    4'h4, 4'h5, 4'h6, 4'h7,
    4'h8, 4'h9, 4'hA, 4'hB,
    4'hC, 4'hD, 4'hE, 4'hF
  };

endpackage

// File: rtl/keypad_hex_entry_scanner.sv
// Column scanner for a 4x4 active-low matrix keypad: dwell divider, column rotation,
// row synchroniser, snapshot assembly and per-scan NONE/SINGLE/MULTI classification.
module keypad_hex_entry_scanner
  import keypad_hex_entry_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       scan_done,
  output logic       scan_none,
  output logic       scan_single,
  output logic       scan_multi,
  output logic [3:0] scan_key
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [3:0]       row_meta_p0;
  logic [3:0]       row_sync_p1;
  logic [15:0]      snap;
  logic [15:0]      snap_next;
  logic             sample;
  logic [4:0]       ones;

  assign sample    = (div_cnt == DIV_LAST);
  assign scan_done = sample && (col_idx == 2'd3);

  // Snapshot as it will look after this cycle's column sample, so the full scan
  // can be classified on the same cycle the last column lands.
  always_comb begin
    snap_next = snap;
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        snap_next[4*r + int'(col_idx)] = ~row_sync_p1[r];
      end
    end
  end

  always_comb begin
    ones     = '0;
    scan_key = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_next[i]) begin
        ones     = ones + 5'd1;
        scan_key = 4'(i);
      end
    end
  end

  assign scan_none   = (ones == 5'd0);
  assign scan_single = (ones == 5'd1);
  assign scan_multi  = (ones > 5'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      col_idx     <= '0;
      col_n       <= COL_RESET;
      row_meta_p0 <= '0;
      row_sync_p1 <= '0;
      snap        <= '0;
    end else begin
      // stage p0 -> p1: two-flop synchroniser for the asynchronous rows
      row_meta_p0 <= row_n;
      row_sync_p1 <= row_meta_p0;
      if (sample) begin
        div_cnt <= '0;
        snap    <= snap_next;
        col_idx <= col_idx + 2'd1;
        col_n   <= {col_n[2:0], col_n[3]};
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_hex_entry.sv
// Keypad hex entry: debounce FSM over whole-keypad scans, one key_valid per confirmed
// press, and a 4-digit entry shift register committed on the rising edge of enter.
module keypad_hex_entry
  import keypad_hex_entry_pkg::*;
#(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  input  logic        enter,
  input  logic        clear,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] entry_value,
  output logic [2:0]  digit_count,
  output logic [15:0] entry_data,
  output logic        entry_valid
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS);

  logic       scan_done;
  logic       scan_none;
  logic       scan_single;
  logic       scan_multi;
  logic [3:0] scan_key;

  kp_state_t        state;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             enter_p1;
  logic             enter_rise;

  function automatic logic [2:0] sat_count(input logic [2:0] c);
    return (c >= 3'd4) ? 3'd4 : c + 3'd1;
  endfunction

  keypad_hex_entry_scanner #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scanner (
    .clk        (clk),
    .reset_n    (reset_n),
    .row_n      (row_n),
    .col_n      (col_n),
    .scan_done  (scan_done),
    .scan_none  (scan_none),
    .scan_single(scan_single),
    .scan_multi (scan_multi),
    .scan_key   (scan_key)
  );

  assign cnt_inc    = cnt + 1'b1;
  assign enter_rise = enter && !enter_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        case (state)
          ST_IDLE: begin
            if (scan_single) begin
              state <= ST_DEBOUNCE;
              cand  <= scan_key;
              cnt   <= CNT_W'(1);
            end
          end
          ST_DEBOUNCE: begin
            // A different key or a chord is treated as bounce and restarts detection.
            if (scan_single && scan_key == cand) begin
              if (cnt_inc == DEB_LAST) begin
                key_code  <= KEY_HEX[cand];
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= ST_HELD;
                cnt       <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end
          ST_HELD: begin
            if (scan_none) begin
              state <= ST_RELEASE;
              cnt   <= CNT_W'(1);
            end
          end
          ST_RELEASE: begin
            if (scan_none) begin
              if (cnt_inc == DEB_LAST) begin
                state    <= ST_IDLE;
                key_held <= 1'b0;
                cnt      <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (scan_single || scan_multi) begin
              state <= ST_HELD;
              cnt   <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Entry register: clear beats commit beats digit shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enter_p1    <= 1'b0;
      entry_value <= '0;
      digit_count <= '0;
      entry_data  <= '0;
      entry_valid <= 1'b0;
    end else begin
      enter_p1    <= enter;
      entry_valid <= 1'b0;
      if (clear) begin
        entry_value <= '0;
        digit_count <= '0;
      end else if (enter_rise) begin
        entry_data  <= entry_value;
        entry_valid <= 1'b1;
        if (key_valid) begin
          entry_value <= {12'h000, key_code};
          digit_count <= 3'd1;
        end else begin
          entry_value <= '0;
          digit_count <= '0;
        end
      end else if (key_valid) begin
        entry_value <= {entry_value[11:0], key_code};
        digit_count <= sat_count(digit_count);
      end
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Scoreboard bench for keypad_hex_entry with a behavioural 4x4 keypad model.
module tb_keypad_hex_entry;

  localparam int SCAN_DIV  = 4;
  localparam int DEB       = 3;
  localparam int SCAN_CLKS = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        enter = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] entry_value;
  logic [2:0]  digit_count;
  logic [15:0] entry_data;
  logic        entry_valid;

  logic [15:0] pressed = '0;
  int checks = 0;
  int failures = 0;
  int kv_count = 0;
  int ev_count = 0;
  logic [3:0]  key_q[$];
  logic [15:0] entry_q[$];
  logic [3:0]  mon_key;
  logic [15:0] mon_entry;
  logic [15:0] exp_val;
  logic [2:0]  exp_cnt;

  keypad_hex_entry #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .row_n      (row_n),
    .col_n      (col_n),
    .enter      (enter),
    .clear      (clear),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .entry_value(entry_value),
    .digit_count(digit_count),
    .entry_data (entry_data),
    .entry_valid(entry_valid)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key at {row,col} pulls its row low while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_n[c] && pressed[4*r+c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (reset_n && key_valid) begin
      kv_count++;
      checks++;
      if (key_q.size() == 0) begin
        failures++;
        $display("FAIL key_unexpected got=%h required=none", key_code);
      end else begin
        mon_key = key_q.pop_front();
        if (key_code !== mon_key) begin
          failures++;
          $display("FAIL key_code got=%h required=%h", key_code, mon_key);
        end
      end
    end
    if (reset_n && entry_valid) begin
      ev_count++;
      checks++;
      if (entry_q.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected got=%h required=none", entry_data);
      end else begin
        mon_entry = entry_q.pop_front();
        if (entry_data !== mon_entry) begin
          failures++;
          $display("FAIL entry_data got=%h required=%h", entry_data, mon_entry);
        end
      end
    end
  end

  task automatic align_scan();
    logic [3:0] prev;
    bit found;
    found = 0;
    prev  = col_n;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk); #1;
      if (col_n == 4'b1110 && prev == 4'b0111) found = 1;
      prev = col_n;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL scan_align col_n=%b required=1110_after_0111", col_n);
    end
  endtask

  task automatic wait_scans(input int n);
    repeat (n * SCAN_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] seq [4];
    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    repeat (7) @(posedge clk);
    #3; reset_n = 1'b0; #1;
    checks++;
    if (col_n !== 4'b1110) begin
      failures++; $display("FAIL reset_col got=%b required=1110", col_n);
    end
    checks++;
    if ({key_code, key_valid, key_held, entry_value, digit_count, entry_data, entry_valid} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b/%b/%h/%0d/%h/%b required=all_zero",
               key_code, key_valid, key_held, entry_value, digit_count, entry_data, entry_valid);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (col_n !== 4'b1110) begin
      failures++; $display("FAIL col_dwell got=%b required=1110", col_n);
    end
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 1 : SCAN_DIV) @(posedge clk);
      #1;
      checks++;
      if (col_n !== seq[k]) begin
        failures++; $display("FAIL col_step%0d got=%b required=%b", k, col_n, seq[k]);
      end
    end
  endtask

  task automatic test_single_press();
    int kv0;
    align_scan();
    kv0 = kv_count;
    pressed = 16'h0040;
    key_q.push_back(4'h6);
    wait_scans(6);
    checks++;
    if (kv_count !== kv0 + 1 || key_code !== 4'h6 || key_held !== 1'b1) begin
      failures++;
      $display("FAIL press6 pulses=%0d code=%h held=%b required=1/6/1", kv_count - kv0, key_code, key_held);
    end
    checks++;
    if (entry_value !== 16'h0006 || digit_count !== 3'd1) begin
      failures++; $display("FAIL entry_first got=%h/%0d required=0006/1", entry_value, digit_count);
    end
    pressed = '0;
    wait_scans(2);
    checks++;
    if (key_held !== 1'b1) begin
      failures++; $display("FAIL held_2empty got=%b required=1", key_held);
    end
    wait_scans(1);
    checks++;
    if (key_held !== 1'b0) begin
      failures++; $display("FAIL held_3empty got=%b required=0", key_held);
    end
  endtask

  task automatic test_bounce();
    int kv0;
    align_scan();
    kv0 = kv_count;
    for (int i = 0; i < 3; i++) begin
      pressed = 16'h0040; wait_scans(2);
      pressed = '0;       wait_scans(1);
    end
    wait_scans(2);
    checks++;
    if (kv_count !== kv0 || key_held !== 1'b0) begin
      failures++; $display("FAIL bounce pulses=%0d held=%b required=0/0", kv_count - kv0, key_held);
    end
  endtask

  task automatic test_multi();
    int kv0;
    align_scan();
    kv0 = kv_count;
    pressed = 16'h0022;
    wait_scans(10);
    checks++;
    if (kv_count !== kv0 || key_held !== 1'b0) begin
      failures++; $display("FAIL multi pulses=%0d held=%b required=0/0", kv_count - kv0, key_held);
    end
    pressed = '0;
    wait_scans(4);
  endtask

  task automatic test_entry_commit();
    int ev0;
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    checks++;
    if (entry_value !== 16'h0 || digit_count !== 3'd0) begin
      failures++; $display("FAIL clear got=%h/%0d required=0000/0", entry_value, digit_count);
    end
    exp_val = '0; exp_cnt = '0;
    align_scan();
    for (int k = 1; k <= 5; k++) begin
      pressed = 16'(1) << k;
      key_q.push_back(4'(k));
      exp_val = {exp_val[11:0], 4'(k)};
      exp_cnt = (exp_cnt == 3'd4) ? 3'd4 : exp_cnt + 3'd1;
      wait_scans(4);
      checks++;
      if (entry_value !== exp_val || digit_count !== exp_cnt) begin
        failures++;
        $display("FAIL entry_key%0d got=%h/%0d required=%h/%0d", k, entry_value, digit_count, exp_val, exp_cnt);
      end
      pressed = '0;
      wait_scans(4);
    end
    enter = 1'b1;
    entry_q.push_back(16'h2345);
    @(posedge clk); #1;
    checks++;
    if (entry_valid !== 1'b1 || entry_data !== 16'h2345 || entry_value !== 16'h0 || digit_count !== 3'd0) begin
      failures++;
      $display("FAIL commit got=%b/%h/%h/%0d required=1/2345/0000/0", entry_valid, entry_data, entry_value, digit_count);
    end
    @(posedge clk); #1;
    checks++;
    if (entry_valid !== 1'b0) begin
      failures++; $display("FAIL commit_width got=%b required=0", entry_valid);
    end
    ev0 = ev_count;
    repeat (20) @(posedge clk); #1;
    checks++;
    if (ev_count !== ev0) begin
      failures++; $display("FAIL enter_held extra_commits=%0d required=0", ev_count - ev0);
    end
    enter = 1'b0;
    repeat (2) @(posedge clk); #1;
    enter = 1'b1;
    entry_q.push_back(16'h0000);
    @(posedge clk); #1;
    checks++;
    if (entry_valid !== 1'b1 || entry_data !== 16'h0000) begin
      failures++; $display("FAIL empty_commit got=%b/%h required=1/0000", entry_valid, entry_data);
    end
    enter = 1'b0;
  endtask

  task automatic test_reset_debounce();
    int kv0;
    align_scan();
    pressed = 16'h0400;
    key_q.push_back(4'hA);
    wait_scans(2);
    repeat (5) @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    kv0 = kv_count;
    reset_n = 1'b1;
    repeat (3 * SCAN_CLKS - 1) @(posedge clk); #1;
    checks++;
    if (kv_count !== kv0 || key_held !== 1'b0) begin
      failures++; $display("FAIL rst_debounce_early pulses=%0d held=%b required=0/0", kv_count - kv0, key_held);
    end
    @(posedge clk); #1;
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'hA || key_held !== 1'b1) begin
      failures++; $display("FAIL rst_debounce_fire got=%b/%h/%b required=1/a/1", key_valid, key_code, key_held);
    end
    @(posedge clk); #1;
    checks++;
    if (entry_value !== 16'h000A || digit_count !== 3'd1) begin
      failures++; $display("FAIL rst_entry got=%h/%0d required=000a/1", entry_value, digit_count);
    end
    pressed = '0;
    wait_scans(4);
  endtask

  task automatic test_clear_with_key();
    align_scan();
    pressed = 16'h8000;
    key_q.push_back(4'hF);
    repeat (3 * SCAN_CLKS) @(posedge clk); #1;
    checks++;
    if (key_valid !== 1'b1) begin
      failures++; $display("FAIL clear_key_pulse got=%b required=1", key_valid);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (entry_value !== 16'h0 || digit_count !== 3'd0) begin
      failures++; $display("FAIL clear_with_key got=%h/%0d required=0000/0", entry_value, digit_count);
    end
    pressed = '0;
    wait_scans(4);
  endtask

  task automatic test_enter_with_key();
    align_scan();
    pressed = 16'h0008;
    key_q.push_back(4'h3);
    wait_scans(4);
    pressed = '0;
    wait_scans(4);
    checks++;
    if (entry_value !== 16'h0003 || digit_count !== 3'd1) begin
      failures++; $display("FAIL pre_enter got=%h/%0d required=0003/1", entry_value, digit_count);
    end
    align_scan();
    pressed = 16'h0200;
    key_q.push_back(4'h9);
    entry_q.push_back(16'h0003);
    repeat (3 * SCAN_CLKS) @(posedge clk); #1;
    checks++;
    if (key_valid !== 1'b1) begin
      failures++; $display("FAIL enter_key_pulse got=%b required=1", key_valid);
    end
    enter = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (entry_valid !== 1'b1 || entry_data !== 16'h0003 || entry_value !== 16'h0009 || digit_count !== 3'd1) begin
      failures++;
      $display("FAIL enter_with_key got=%b/%h/%h/%0d required=1/0003/0009/1", entry_valid, entry_data, entry_value, digit_count);
    end
    enter = 1'b0;
    pressed = '0;
    wait_scans(4);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_entry_commit();
    test_reset_debounce();
    test_clear_with_key();
    test_enter_with_key();
    checks++;
    if (key_q.size() != 0 || entry_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain keys_left=%0d commits_left=%0d required=0/0", key_q.size(), entry_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
